matrix_xfer_ctrl: RTL and testbench
===================================

// Module: matrix_xfer_ctrl
// PURPOSE
//  Parametrised HPS<->coprocessor transfer controller; successor to the fixed 5x5/8-bit control unit.
//  Loads operand matrices A/B over a four-phase req/ack handshake, launches the matrix coprocessor,
//  then streams results back. Moves only n*n elements for the configured size; zero-fills the rest.
//  Sits between the HPS PIO words and the matrix coprocessor instance.
// PARAMETERS
//  DATA_W      8    element width (signed), also scalar width
//  MAX_N       5    maximum matrix dimension; flat buses hold MAX_N*MAX_N elements
//  SYNC_STAGES 3    synchroniser depth on hps_req (>=2)
//  TIMEOUT_CYC 1024 RUN watchdog limit (used only with XFER_TIMEOUT_EN)
// PORTS
//  clk         in  1                  system clock
//  reset       in  1                  synchronous, active-high reset
//  hps_start   in  1                  level; begin a transaction when IDLE
//  hps_req     in  1                  HPS handshake request (async to clk, synchronised)
//  hps_a       in  DATA_W             element of A for current beat
//  hps_b       in  DATA_W             element of B for current beat
//  hps_op      in  3                  opcode, captured on first LOAD beat
//  hps_size    in  2                  size code; n = min(hps_size+2, MAX_N), captured on first beat
//  hps_scalar  in  DATA_W             scalar, captured on first beat
//  fpga_ack    out 1                  handshake acknowledge
//  fpga_data   out DATA_W             result element; valid while fpga_ack=1 in DRAIN
//  busy        out 1                  state != IDLE
//  ovf         out 1                  overflow of last completed operation
//  err         out 1                  watchdog fired (0 when XFER_TIMEOUT_EN undefined)
//  cp_start    out 1                  one-cycle coprocessor launch pulse
//  cp_op/cp_size/cp_scalar out 3/2/DATA_W  registered operation config
//  cp_a, cp_b  out MAX_N*MAX_N*DATA_W flat operands, element k at [k*DATA_W +: DATA_W]
//  cp_result   in  MAX_N*MAX_N*DATA_W flat result
//  cp_done     in  1                  coprocessor completion (sampled in RUN only)
//  cp_ovf      in  1                  overflow, sampled with cp_done
// BEHAVIOUR
//  Reset: state IDLE, all outputs 0, A/B/result storage 0, index 0, ovf/err 0.
//  hps_req -> SYNC_STAGES flops -> rising-edge detect; req pin to ack rise = SYNC_STAGES+1 cycles.
//  fpga_ack = registered (state in {LOAD,DRAIN}) && req_sync; falls SYNC_STAGES+1 cycles after req falls.
//  IDLE : hps_start=1 -> clear A/B, index=0, go LOAD. req edges ignored.
//  LOAD : each req rising edge writes A[index],B[index], index++; beat 0 also latches op/size/scalar.
//         Element index is row-major in an n x n view mapped to the MAX_N-stride flat slot (r*MAX_N+c).
//         After beat n*n-1: index=0, cp_start pulse, go RUN.
//  RUN  : cp_done=1 -> copy cp_result, ovf<=cp_ovf, index=0, go DRAIN. Further cp_done ignored.
//  DRAIN: fpga_data registered from result[slot(index)] before ack rises; each req edge index++;
//         edge on beat n*n-1 -> go IDLE (ack still completes its fall).
//  hps_start while busy: ignored. Size code >MAX_N-2: clamp n=MAX_N.
//  Simultaneous start and req edge in IDLE: start wins, edge dropped.
//  Reset mid-transaction: abort to IDLE next cycle, storage cleared, no cp_start.
//  Index never exceeds n*n-1; no wrap-around.
// CONFIGURATION
//  XFER_TIMEOUT_EN defined: cycle counter in RUN; reaching TIMEOUT_CYC without cp_done -> err<=1,
//    go IDLE; err clears on next accepted hps_start.
//  Undefined: no counter, RUN waits indefinitely, err tied 0.
// STRUCTURE
//  matrix_pkg: state enum (IDLE,LOAD,RUN,DRAIN), OP_W=3, SIZE_W=2, size_to_n() and slot() functions.
//  Sub-module hs_sync: SYNC_STAGES synchroniser + rising-edge pulse; instantiated once for hps_req.
// TESTING
//  Reset: assert 1 cycle mid-LOAD after 7 beats -> IDLE, busy=0, cp_a all 0, no cp_start.
//  Full 5x5 add: size=3, A[k]=k, B[k]=1, 25 beats, cp_result=A+B -> 25 drained values k+1, ovf=0.
//  3x3 load: size=1, 9 beats -> cp_start after beat 9; slots 3,4 and row 3+ of cp_a stay 0.
//  Handshake: hps_req held 40 cycles -> exactly one capture; ack rises 4 cycles after req (SYNC_STAGES=3).
//  Overflow: cp_ovf=1 with cp_done -> ovf=1 throughout DRAIN and after return to IDLE.
//  XFER_TIMEOUT_EN, TIMEOUT_CYC=16, cp_done never -> err=1 at cycle 16 of RUN, IDLE; next start clears err.

Source files
------------

// File: rtl/matrix_pkg.sv
// matrix_pkg: shared types, constants and helpers for the HPS<->coprocessor matrix transfer
// controller.
//  - State encoding of the transfer FSM (IDLE, LOAD, RUN, DRAIN) as plain localparams so the
//    encoding stays stable for software and older tooling that inspects the state register.
//  - OP_W / SIZE_W: widths of the opcode and size-code fields.
//  - size_to_n(): size code -> matrix dimension, clamped to the build's maximum.
//  - slot():      (row, col) of an n x n view -> element slot in the MAX_N-stride flat buffer.
package matrix_pkg;

  localparam int unsigned OP_W   = 3;
  localparam int unsigned SIZE_W = 2;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_LOAD  = 2'd1;
  localparam state_t ST_RUN   = 2'd2;
  localparam state_t ST_DRAIN = 2'd3;

  // n = size + 2, never larger than the buffers can hold.
  function automatic int unsigned size_to_n(input logic [SIZE_W-1:0] size,
                                            input int unsigned max_n);
    int unsigned n;
    n = 32'(size) + 32'd2;
    return (n > max_n) ? max_n : n;
  endfunction

  // Rows always sit MAX_N elements apart, whatever the active dimension.
  function automatic int unsigned slot(input int unsigned row, input int unsigned col,
                                       input int unsigned max_n);
    return row * max_n + col;
  endfunction

endpackage

// File: rtl/hs_sync.sv
// hs_sync: multi-flop synchroniser for an asynchronous level input, plus a one-cycle pulse on
// each synchronised rising edge.
// Parameters:
//  STAGES   synchroniser depth (>= 2)
// Ports:
//  clk       in  system clock
//  reset     in  synchronous, active-high reset
//  async_in  in  asynchronous level input
//  sync_out  out synchronised level (last synchroniser stage)
//  rise      out high for one cycle when sync_out goes 0 -> 1
module hs_sync #(
  parameter int unsigned STAGES = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic sync_out,
  output logic rise
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_in};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign sync_out = sync_q[STAGES-1];
  assign rise     = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/matrix_xfer_ctrl.sv
// matrix_xfer_ctrl: parametrised transfer controller between the HPS PIO words and the matrix
// coprocessor. Loads operands A/B one element per four-phase req/ack beat, launches the
// coprocessor, then streams the result back one element per beat. Only n*n elements move for
// the configured size; unused slots of the operand buffers stay zero.
// Optional feature: define XFER_TIMEOUT_EN to enable a RUN watchdog (TIMEOUT_CYC cycles) that
// raises err and returns to IDLE; without it err is tied low and RUN waits indefinitely.
// Ports:
//  clk, reset                 clock, synchronous active-high reset
//  hps_start                  level; starts a transaction when idle
//  hps_req / fpga_ack         asynchronous request in, acknowledge out
//  hps_a, hps_b               operand elements for the current load beat
//  hps_op, hps_size, hps_scalar  operation config, captured on the first load beat
//  fpga_data                  result element, stable while fpga_ack is high in DRAIN
//  busy, ovf, err             status
//  cp_start, cp_op, cp_size, cp_scalar, cp_a, cp_b   coprocessor launch and operands
//  cp_result, cp_done, cp_ovf coprocessor result and completion
module matrix_xfer_ctrl
  import matrix_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned MAX_N       = 5,
  parameter int unsigned SYNC_STAGES = 3,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            hps_start,
  input  logic                            hps_req,
  input  logic [DATA_W-1:0]               hps_a,
  input  logic [DATA_W-1:0]               hps_b,
  input  logic [OP_W-1:0]                 hps_op,
  input  logic [SIZE_W-1:0]               hps_size,
  input  logic [DATA_W-1:0]               hps_scalar,
  output logic                            fpga_ack,
  output logic [DATA_W-1:0]               fpga_data,
  output logic                            busy,
  output logic                            ovf,
  output logic                            err,
  output logic                            cp_start,
  output logic [OP_W-1:0]                 cp_op,
  output logic [SIZE_W-1:0]               cp_size,
  output logic [DATA_W-1:0]               cp_scalar,
  output logic [MAX_N*MAX_N*DATA_W-1:0]   cp_a,
  output logic [MAX_N*MAX_N*DATA_W-1:0]   cp_b,
  input  logic [MAX_N*MAX_N*DATA_W-1:0]   cp_result,
  input  logic                            cp_done,
  input  logic                            cp_ovf
);

  localparam int unsigned ELEMS  = MAX_N * MAX_N;
  localparam int unsigned RC_W   = (MAX_N > 2) ? $clog2(MAX_N) : 1;
  localparam int unsigned SLOT_W = $clog2(ELEMS);

  state_t              state_q, state_d;
  logic [RC_W-1:0]     row_q, col_q, row_nx, col_nx, n_m1;
  logic [SLOT_W-1:0]   cur_slot;
  logic [SIZE_W-1:0]   eff_size;
  logic                last_col, last_beat;
  logic                start_go, load_beat, drain_beat, done_go, timeout_go;
  logic                req_sync, req_rise;
  logic                ack_q, ack_d;
  logic                start_q, ovf_q;
  logic [DATA_W-1:0]   data_q;
  logic [OP_W-1:0]     op_q;
  logic [SIZE_W-1:0]   size_q;
  logic [DATA_W-1:0]   scalar_q;
  logic [DATA_W-1:0]   a_q   [ELEMS];
  logic [DATA_W-1:0]   b_q   [ELEMS];
  logic [DATA_W-1:0]   res_q [ELEMS];

  hs_sync #(
    .STAGES (SYNC_STAGES)
  ) u_req_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (hps_req),
    .sync_out (req_sync),
    .rise     (req_rise)
  );

`ifdef XFER_TIMEOUT_EN
  localparam int unsigned TIMER_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TIMER_W-1:0] timer_q;
  logic               err_q;
`else
  // TIMEOUT_CYC only matters when the watchdog is built in.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^32'(TIMEOUT_CYC);
`endif

  always_comb begin
    // On the first load beat the size has not been latched yet, so use the live input.
    eff_size   = (state_q == ST_LOAD && row_q == '0 && col_q == '0) ? hps_size : size_q;
    n_m1       = RC_W'(size_to_n(eff_size, MAX_N) - 32'd1);
    last_col   = (col_q == n_m1);
    last_beat  = last_col && (row_q == n_m1);
    cur_slot   = SLOT_W'(slot(32'(row_q), 32'(col_q), MAX_N));

    start_go   = (state_q == ST_IDLE) && hps_start;
    load_beat  = (state_q == ST_LOAD) && req_rise;
    drain_beat = (state_q == ST_DRAIN) && req_rise;
    done_go    = (state_q == ST_RUN) && cp_done;
    timeout_go = 1'b0;
`ifdef XFER_TIMEOUT_EN
    timeout_go = (state_q == ST_RUN) && !cp_done && (timer_q == TIMER_W'(TIMEOUT_CYC - 1));
`endif

    if (last_beat) begin
      row_nx = '0;
      col_nx = '0;
    end else if (last_col) begin
      row_nx = row_q + 1'b1;
      col_nx = '0;
    end else begin
      row_nx = row_q;
      col_nx = col_q + 1'b1;
    end

    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_go) state_d = ST_LOAD;
      ST_LOAD:  if (load_beat && last_beat) state_d = ST_RUN;
      ST_RUN: begin
        if (done_go) state_d = ST_DRAIN;
        else if (timeout_go) state_d = ST_IDLE;
      end
      ST_DRAIN: if (drain_beat && last_beat) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Ack rises only on an accepted beat, then tracks req down even if the FSM has moved on,
    // so the HPS always sees a complete four-phase cycle.
    ack_d = req_sync & (ack_q | (req_rise & (state_q == ST_LOAD || state_q == ST_DRAIN)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      row_q    <= '0;
      col_q    <= '0;
      ack_q    <= 1'b0;
      start_q  <= 1'b0;
      ovf_q    <= 1'b0;
      data_q   <= '0;
      op_q     <= '0;
      size_q   <= '0;
      scalar_q <= '0;
      for (int k = 0; k < ELEMS; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        res_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      start_q <= load_beat && last_beat;

      if (start_go) begin
        row_q <= '0;
        col_q <= '0;
        for (int k = 0; k < ELEMS; k++) begin
          a_q[k] <= '0;
          b_q[k] <= '0;
        end
      end

      if (load_beat) begin
        a_q[cur_slot] <= hps_a;
        b_q[cur_slot] <= hps_b;
        if (row_q == '0 && col_q == '0) begin
          op_q     <= hps_op;
          size_q   <= hps_size;
          scalar_q <= hps_scalar;
        end
      end

      if (load_beat || drain_beat) begin
        row_q <= row_nx;
        col_q <= col_nx;
      end

      if (done_go) begin
        for (int k = 0; k < ELEMS; k++) begin
          res_q[k] <= cp_result[k*DATA_W +: DATA_W];
        end
        ovf_q <= cp_ovf;
        row_q <= '0;
        col_q <= '0;
      end

      // Present the next element only between beats so it cannot change under a raised ack.
      if (state_q == ST_DRAIN && !ack_q && !req_rise) begin
        data_q <= res_q[cur_slot];
      end
    end
  end

`ifdef XFER_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state_q != ST_RUN) begin
        timer_q <= '0;
      end else if (!cp_done) begin
        timer_q <= timer_q + 1'b1;
      end
      if (timeout_go) begin
        err_q <= 1'b1;
      end else if (start_go) begin
        err_q <= 1'b0;
      end
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_comb begin
    cp_a = '0;
    cp_b = '0;
    for (int k = 0; k < ELEMS; k++) begin
      cp_a[k*DATA_W +: DATA_W] = a_q[k];
      cp_b[k*DATA_W +: DATA_W] = b_q[k];
    end
  end

  assign fpga_ack  = ack_q;
  assign fpga_data = data_q;
  assign busy      = (state_q != ST_IDLE);
  assign ovf       = ovf_q;
  assign cp_start  = start_q;
  assign cp_op     = op_q;
  assign cp_size   = size_q;
  assign cp_scalar = scalar_q;

endmodule

// File: tb/tb_matrix_xfer_ctrl.sv
// Self-checking bench for matrix_xfer_ctrl. Acts as the HPS (four-phase req/ack beats) and as
// the coprocessor (returns results from the bench's own model), and checks operands, launch,
// drained data and status against expectations computed from n, row-major order and the
// MAX_N-stride slot layout.
module tb_matrix_xfer_ctrl;

  localparam int unsigned DATA_W      = 8;
  localparam int unsigned MAX_N       = 5;
  localparam int unsigned SYNC_STAGES = 3;
  localparam int unsigned TIMEOUT_CYC = 16;
  localparam int unsigned ELEMS       = MAX_N * MAX_N;
  localparam int unsigned FW          = ELEMS * DATA_W;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              hps_start = 1'b0;
  logic              hps_req = 1'b0;
  logic [DATA_W-1:0] hps_a = '0, hps_b = '0, hps_scalar = '0;
  logic [2:0]        hps_op = '0;
  logic [1:0]        hps_size = '0;
  logic              fpga_ack, busy, ovf, err, cp_start;
  logic [DATA_W-1:0] fpga_data, cp_scalar;
  logic [2:0]        cp_op;
  logic [1:0]        cp_size;
  logic [FW-1:0]     cp_a, cp_b;
  logic [FW-1:0]     cp_result = '0;
  logic              cp_done = 1'b0, cp_ovf = 1'b0;

  int errors = 0;
  int checks = 0;
  int start_pulses = 0;

  logic [DATA_W-1:0] src_a [ELEMS];
  logic [DATA_W-1:0] src_b [ELEMS];
  logic [DATA_W-1:0] res_m [ELEMS];

  always #5 clk = ~clk;

  always @(negedge clk) if (cp_start === 1'b1) start_pulses++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  matrix_xfer_ctrl #(
    .DATA_W      (DATA_W),
    .MAX_N       (MAX_N),
    .SYNC_STAGES (SYNC_STAGES),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .hps_start  (hps_start),
    .hps_req    (hps_req),
    .hps_a      (hps_a),
    .hps_b      (hps_b),
    .hps_op     (hps_op),
    .hps_size   (hps_size),
    .hps_scalar (hps_scalar),
    .fpga_ack   (fpga_ack),
    .fpga_data  (fpga_data),
    .busy       (busy),
    .ovf        (ovf),
    .err        (err),
    .cp_start   (cp_start),
    .cp_op      (cp_op),
    .cp_size    (cp_size),
    .cp_scalar  (cp_scalar),
    .cp_a       (cp_a),
    .cp_b       (cp_b),
    .cp_result  (cp_result),
    .cp_done    (cp_done),
    .cp_ovf     (cp_ovf)
  );

  // ---------------- reference model ----------------
  function automatic int n_of(input int size);
    return (size + 2 > int'(MAX_N)) ? int'(MAX_N) : size + 2;
  endfunction

  function automatic int slot_of(input int k, input int n);
    return (k / n) * int'(MAX_N) + (k % n);
  endfunction

  function automatic logic [FW-1:0] flat_of(input logic is_b, input int n, input int cnt);
    logic [FW-1:0] f;
    f = '0;
    for (int k = 0; k < cnt; k++) begin
      f[slot_of(k, n)*DATA_W +: DATA_W] = is_b ? src_b[k] : src_a[k];
    end
    return f;
  endfunction

  // ---------------- HPS / coprocessor drivers ----------------
  task automatic wait_ack(input logic level, input string what);
    int cyc;
    cyc = 0;
    while (fpga_ack !== level && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (fpga_ack !== level) begin
      errors++;
      $display("FAIL %s: fpga_ack=%b after %0d cycles, required %b", what, fpga_ack, cyc, level);
    end
  endtask

  task automatic hps_beat(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    hps_a   = a;
    hps_b   = b;
    hps_req = 1'b1;
    wait_ack(1'b1, "beat_ack_rise");
    hps_req = 1'b0;
    wait_ack(1'b0, "beat_ack_fall");
  endtask

  task automatic hps_read(output logic [DATA_W-1:0] d);
    hps_req = 1'b1;
    wait_ack(1'b1, "read_ack_rise");
    d = fpga_data;
    hps_req = 1'b0;
    wait_ack(1'b0, "read_ack_fall");
  endtask

  task automatic start_txn(input logic [2:0] op, input logic [1:0] size,
                           input logic [DATA_W-1:0] scalar);
    hps_op     = op;
    hps_size   = size;
    hps_scalar = scalar;
    hps_start  = 1'b1;
    @(negedge clk);
    hps_start  = 1'b0;
  endtask

  task automatic load_all(input int cnt);
    for (int k = 0; k < cnt; k++) hps_beat(src_a[k], src_b[k]);
  endtask

  task automatic cp_respond(input logic ovf_v);
    for (int s = 0; s < int'(ELEMS); s++) cp_result[s*DATA_W +: DATA_W] = res_m[s];
    cp_ovf  = ovf_v;
    cp_done = 1'b1;
    @(negedge clk);
    cp_done = 1'b0;
    cp_ovf  = 1'b0;
  endtask

  task automatic fill_random(input int cnt);
    for (int k = 0; k < cnt; k++) begin
      src_a[k] = DATA_W'($urandom_range(1, 255));
      src_b[k] = DATA_W'($urandom_range(1, 255));
    end
    for (int s = 0; s < int'(ELEMS); s++) res_m[s] = DATA_W'($urandom);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int base;
    checks++;
    if (busy !== 1'b0 || fpga_ack !== 1'b0 || ovf !== 1'b0 || err !== 1'b0 || cp_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: busy=%b ack=%b ovf=%b err=%b cp_start=%b, required all 0",
               busy, fpga_ack, ovf, err, cp_start);
    end
    checks++;
    if (fpga_data !== '0 || cp_op !== '0 || cp_size !== '0 || cp_scalar !== '0) begin
      errors++;
      $display("FAIL reset_regs: data=%h op=%h size=%h scalar=%h, required 0",
               fpga_data, cp_op, cp_size, cp_scalar);
    end
    checks++;
    if (cp_a !== '0 || cp_b !== '0) begin
      errors++;
      $display("FAIL reset_storage: cp_a=%h cp_b=%h, required 0", cp_a, cp_b);
    end
    // Abort mid-load after 7 beats of a 5x5 transfer.
    base = start_pulses;
    fill_random(7);
    start_txn(3'd2, 2'd3, 8'h11);
    load_all(7);
    checks++;
    if (busy !== 1'b1 || cp_a !== flat_of(1'b0, 5, 7)) begin
      errors++;
      $display("FAIL abort_preload: busy=%b cp_a=%h, required busy=1 cp_a=%h",
               busy, cp_a, flat_of(1'b0, 5, 7));
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || cp_a !== '0 || cp_b !== '0) begin
      errors++;
      $display("FAIL abort_clear: busy=%b cp_a=%h cp_b=%h, required busy=0 and zero storage",
               busy, cp_a, cp_b);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (start_pulses != base || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_launch: cp_start pulses=%0d busy=%b, required 0 and 0",
               start_pulses - base, busy);
    end
  endtask

  task automatic test_full_add();
    int base;
    logic [DATA_W-1:0] d;
    for (int k = 0; k < 25; k++) begin
      src_a[k] = DATA_W'(k);
      src_b[k] = 8'd1;
    end
    for (int s = 0; s < int'(ELEMS); s++) res_m[s] = '0;
    for (int k = 0; k < 25; k++) res_m[slot_of(k, 5)] = src_a[k] + src_b[k];
    base = start_pulses;
    start_txn(3'd0, 2'd3, 8'h5a);
    load_all(25);
    checks++;
    if (start_pulses - base != 1) begin
      errors++;
      $display("FAIL add_launch: cp_start pulses=%0d, required 1", start_pulses - base);
    end
    checks++;
    if (cp_a !== flat_of(1'b0, 5, 25) || cp_b !== flat_of(1'b1, 5, 25)) begin
      errors++;
      $display("FAIL add_operands: cp_a=%h cp_b=%h, required %h / %h",
               cp_a, cp_b, flat_of(1'b0, 5, 25), flat_of(1'b1, 5, 25));
    end
    checks++;
    if (cp_op !== 3'd0 || cp_size !== 2'd3 || cp_scalar !== 8'h5a || busy !== 1'b1) begin
      errors++;
      $display("FAIL add_config: op=%0d size=%0d scalar=%h busy=%b, required 0 3 5a 1",
               cp_op, cp_size, cp_scalar, busy);
    end
    cp_respond(1'b0);
    for (int k = 0; k < 25; k++) begin
      hps_read(d);
      checks++;
      if (d !== DATA_W'(k + 1)) begin
        errors++;
        $display("FAIL add_drain[%0d]: got %0d, required %0d", k, d, k + 1);
      end
    end
    checks++;
    if (ovf !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL add_end: ovf=%b busy=%b, required 0 0", ovf, busy);
    end
  endtask

  task automatic test_3x3();
    int base;
    logic [DATA_W-1:0] d;
    fill_random(9);
    base = start_pulses;
    start_txn(3'd1, 2'd1, 8'h03);
    load_all(8);
    checks++;
    if (start_pulses != base || busy !== 1'b1) begin
      errors++;
      $display("FAIL n3_early_launch: pulses=%0d busy=%b after 8 beats, required 0 1",
               start_pulses - base, busy);
    end
    hps_beat(src_a[8], src_b[8]);
    checks++;
    if (start_pulses - base != 1) begin
      errors++;
      $display("FAIL n3_launch: pulses=%0d after 9 beats, required 1", start_pulses - base);
    end
    checks++;
    if (cp_a[3*DATA_W +: 2*DATA_W] !== '0 || cp_a[FW-1:15*DATA_W] !== '0) begin
      errors++;
      $display("FAIL n3_zero_fill: slots3-4=%h rows3+=%h, required 0",
               cp_a[3*DATA_W +: 2*DATA_W], cp_a[FW-1:15*DATA_W]);
    end
    checks++;
    if (cp_a !== flat_of(1'b0, 3, 9) || cp_b !== flat_of(1'b1, 3, 9) || cp_size !== 2'd1) begin
      errors++;
      $display("FAIL n3_operands: cp_a=%h cp_b=%h size=%0d, required %h / %h / 1",
               cp_a, cp_b, cp_size, flat_of(1'b0, 3, 9), flat_of(1'b1, 3, 9));
    end
    cp_respond(1'b0);
    for (int k = 0; k < 9; k++) begin
      hps_read(d);
      checks++;
      if (d !== res_m[slot_of(k, 3)]) begin
        errors++;
        $display("FAIL n3_drain[%0d]: got %h, required %h", k, d, res_m[slot_of(k, 3)]);
      end
    end
  endtask

  task automatic test_handshake();
    int base, cyc, held;
    logic [DATA_W-1:0] d;
    fill_random(4);
    base = start_pulses;
    start_txn(3'd3, 2'd0, 8'h00);
    hps_a   = src_a[0];
    hps_b   = src_b[0];
    hps_req = 1'b1;
    cyc = 0;
    while (fpga_ack !== 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc != int'(SYNC_STAGES) + 1) begin
      errors++;
      $display("FAIL hs_rise_latency: %0d cycles, required %0d", cyc, SYNC_STAGES + 1);
    end
    held = cyc;
    while (held < 40) begin
      @(negedge clk);
      held++;
    end
    hps_req = 1'b0;
    cyc = 0;
    while (fpga_ack !== 1'b0 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc != int'(SYNC_STAGES) + 1) begin
      errors++;
      $display("FAIL hs_fall_latency: %0d cycles, required %0d", cyc, SYNC_STAGES + 1);
    end
    load_all(0);
    hps_beat(src_a[1], src_b[1]);
    hps_beat(src_a[2], src_b[2]);
    checks++;
    if (start_pulses != base) begin
      errors++;
      $display("FAIL hs_single_capture: launch after 3 beats (pulses=%0d), required 0",
               start_pulses - base);
    end
    hps_beat(src_a[3], src_b[3]);
    checks++;
    if (start_pulses - base != 1 || cp_a !== flat_of(1'b0, 2, 4)) begin
      errors++;
      $display("FAIL hs_operands: pulses=%0d cp_a=%h, required 1 / %h",
               start_pulses - base, cp_a, flat_of(1'b0, 2, 4));
    end
    cp_respond(1'b0);
    for (int k = 0; k < 4; k++) hps_read(d);
  endtask

  task automatic test_overflow();
    logic [DATA_W-1:0] d;
    fill_random(4);
    start_txn(3'd0, 2'd0, 8'h00);
    load_all(4);
    cp_respond(1'b1);
    // A late completion with different data must not disturb DRAIN.
    for (int s = 0; s < int'(ELEMS); s++) cp_result[s*DATA_W +: DATA_W] = ~res_m[s];
    cp_done = 1'b1;
    @(negedge clk);
    cp_done = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (ovf !== 1'b1) begin
        errors++;
        $display("FAIL ovf_drain[%0d]: ovf=%b, required 1", k, ovf);
      end
      hps_read(d);
      checks++;
      if (d !== res_m[slot_of(k, 2)]) begin
        errors++;
        $display("FAIL ovf_data[%0d]: got %h, required %h", k, d, res_m[slot_of(k, 2)]);
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (ovf !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ovf_idle: ovf=%b busy=%b, required 1 0", ovf, busy);
    end
  endtask

  task automatic test_random();
    logic [DATA_W-1:0] d;
    logic [1:0] size;
    logic [2:0] op;
    logic ovf_v;
    int n;
    for (int t = 0; t < 3; t++) begin
      size  = 2'($urandom_range(0, 3));
      op    = 3'($urandom);
      ovf_v = 1'($urandom);
      n     = n_of(int'(size));
      fill_random(n * n);
      start_txn(op, size, 8'(t + 7));
      load_all(n * n);
      checks++;
      if (cp_a !== flat_of(1'b0, n, n * n) || cp_b !== flat_of(1'b1, n, n * n) ||
          cp_op !== op || cp_size !== size || cp_scalar !== 8'(t + 7)) begin
        errors++;
        $display("FAIL rnd%0d_operands: cp_a=%h cp_b=%h op=%0d size=%0d, required %h / %h / %0d / %0d",
                 t, cp_a, cp_b, cp_op, cp_size, flat_of(1'b0, n, n * n), flat_of(1'b1, n, n * n),
                 op, size);
      end
      hps_start = 1'b1;
      @(negedge clk);
      hps_start = 1'b0;
      checks++;
      if (busy !== 1'b1 || cp_a !== flat_of(1'b0, n, n * n)) begin
        errors++;
        $display("FAIL rnd%0d_start_busy: busy=%b cp_a=%h, required 1 and unchanged", t, busy, cp_a);
      end
      cp_respond(ovf_v);
      for (int k = 0; k < n * n; k++) begin
        hps_read(d);
        checks++;
        if (d !== res_m[slot_of(k, n)]) begin
          errors++;
          $display("FAIL rnd%0d_drain[%0d]: got %h, required %h", t, k, d, res_m[slot_of(k, n)]);
        end
      end
      checks++;
      if (ovf !== ovf_v || busy !== 1'b0) begin
        errors++;
        $display("FAIL rnd%0d_end: ovf=%b busy=%b, required %b 0", t, ovf, busy, ovf_v);
      end
    end
  endtask

  task automatic test_timeout();
    int cyc;
    logic [DATA_W-1:0] d;
    fill_random(4);
    start_txn(3'd0, 2'd0, 8'h00);
    load_all(3);
`ifdef XFER_TIMEOUT_EN
    hps_a   = src_a[3];
    hps_b   = src_b[3];
    hps_req = 1'b1;
    wait_ack(1'b1, "to_last_beat");
    cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc != int'(TIMEOUT_CYC) || err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_fire: idle after %0d RUN cycles err=%b, required %0d and 1",
               cyc, err, TIMEOUT_CYC);
    end
    hps_req = 1'b0;
    wait_ack(1'b0, "to_ack_fall");
    start_txn(3'd0, 2'd0, 8'h00);
    checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_clear: err=%b busy=%b, required 0 1", err, busy);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    d = '0;
`else
    hps_beat(src_a[3], src_b[3]);
    cyc = 0;
    repeat (40) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (busy !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL run_wait: busy=%b err=%b after %0d cycles, required 1 0", busy, err, cyc);
    end
    cp_respond(1'b0);
    for (int k = 0; k < 4; k++) begin
      hps_read(d);
      checks++;
      if (d !== res_m[slot_of(k, 2)]) begin
        errors++;
        $display("FAIL run_wait_drain[%0d]: got %h, required %h", k, d, res_m[slot_of(k, 2)]);
      end
    end
`endif
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    test_reset();
    test_full_add();
    test_3x3();
    test_handshake();
    test_overflow();
    test_random();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
